fft64_output_reorder: RTL and testbench
=======================================

Name: fft64_output_reorder

Overview:
Downstream neighbour of the final scaling shifter (divide-by-64) in the 64-point FFT datapath. It accepts the scaled complex results, which arrive in bit-reversed order, one per cycle. It stores them in a two-bank ping-pong buffer and re-emits each frame in natural order (bin 0..63) over a valid/ready handshake. One bank fills while the other drains, so streaming throughput is one sample per cycle.

Parameters:
DATA_WIDTH, 16, width of each real/imag component (matches the shifter output)
N_POINTS, 64, samples per frame
LOG2N, 6, address/index width; N_POINTS = 2**LOG2N

Ports:
Clock  in  1  single clock; all state changes on rising edge
Reset  in  1  synchronous, active-high reset
In_Valid  in  1  upstream sample valid
In_Ready  out  1  block can accept a sample this cycle
In_Real  in  DATA_WIDTH  scaled real part, two's complement
In_Imag  in  DATA_WIDTH  scaled imag part, two's complement
Out_Valid  out  1  output sample valid
Out_Ready  in  1  downstream accepts the output sample
Out_Real  out  DATA_WIDTH  real part, natural order
Out_Imag  out  DATA_WIDTH  imag part, natural order
Out_Index  out  LOG2N  frequency bin of the current output (0..63)
Out_Last  out  1  high with bin 63 of each frame

Behaviour:
- Interface: one clock (Clock). Reset is synchronous and active-high (Reset). No other clock or reset.
- Storage: 2 banks × N_POINTS × (2·DATA_WIDTH). Per-bank Full flag.
- Write side state: Wr_Bank (1b), Wr_Cnt (LOG2N).
- Read side state: Rd_Bank (1b), Rd_Cnt (LOG2N).
- Reset values: Wr_Bank=0, Rd_Bank=0, Wr_Cnt=0, Rd_Cnt=0, both Full=0.
- Outputs after reset: In_Ready=1, Out_Valid=0, Out_Index=0, Out_Last=0.
- Memory contents are not reset. Out_Real and Out_Imag are don't-care while Out_Valid=0.
- Write acceptance: In_Ready = !Full[Wr_Bank]. A write is accepted when In_Valid && In_Ready.
- On accept: mem[Wr_Bank][bitrev(Wr_Cnt)] <= {In_Real, In_Imag}; Wr_Cnt increments.
  - bitrev mirrors bits [5:0], e.g. 1->32, 3->48.
- On accepting the sample with Wr_Cnt=63: Wr_Cnt wraps to 0, Full[Wr_Bank] <= 1, Wr_Bank toggles.
- In_Ready therefore drops the following cycle only if the other bank is still full.
- Read side: Out_Valid = Full[Rd_Bank].
  - Out_Real/Out_Imag = mem[Rd_Bank][Rd_Cnt], combinational from registered state.
  - Out_Index = Rd_Cnt; Out_Last = Out_Valid && (Rd_Cnt == 63).
- Read acceptance: an output is consumed when Out_Valid && Out_Ready. On consume, Rd_Cnt increments.
- When bin 63 is consumed: Rd_Cnt wraps to 0, Full[Rd_Bank] <= 0, Rd_Bank toggles.
- Backpressure: while Out_Valid && !Out_Ready, all outputs hold stable.
- Latency: if the 64th write is accepted at edge N and the read side is idle, Out_Valid=1 with Out_Index=0 in the cycle after edge N.
- Simultaneous events:
  - A write completing one bank and a read completing the other bank in the same edge are independent; both flag updates take effect.
  - The writer never targets a full bank and the reader never reads a non-full bank, so a set and a clear of the same Full flag in one edge cannot occur.
- Continuous streaming: with In_Valid=1 and Out_Ready=1 held, In_Ready stays 1 and throughput is 1 sample/cycle each side after the first frame.
- Both banks full: In_Ready=0; input data is ignored until the read side frees a bank.
- Reset mid-frame: partial write and read frames are discarded; state returns to reset values on the next edge.
- No arithmetic is performed; data passes bit-exact, with no sign extension or truncation.

Test Plan:
1. Reset asserted 2 cycles, then released -> In_Ready=1, Out_Valid=0, Out_Index=0, Out_Last=0.
2. Write 64 samples in order k=0..63 with In_Real=bitrev(k), In_Imag=-bitrev(k), Out_Ready=1 -> first Out_Valid one cycle after the last write. Out_Index runs 0..63 with Out_Real=Out_Index and Out_Imag=-Out_Index. Out_Last is high only at 63.
3. Stream 3 back-to-back frames with Out_Ready=1 -> In_Ready never drops, no gaps on Out_Valid after frame 1, 192 outputs correct and in order.
4. Out_Ready=0 while 2 frames are written -> In_Ready=0 after the 128th accept and the 129th sample is not written. Outputs hold at bin 0 of frame 1; raising Out_Ready drains both frames intact.
5. Random Out_Ready toggling (50%) during streaming -> outputs stay stable whenever Out_Valid && !Out_Ready, with no loss or duplication over 10 frames.
6. Reset at the 40th write, with a frame half drained -> next cycle Out_Valid=0 and In_Ready=1. The following full frame is output correctly, starting at Out_Index 0.

Source files
------------

// File: rtl/fft64_output_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 64-point FFT output.
// Two-bank ping-pong memory: one bank fills in bit-reversed order while the other drains in bin order.
module fft64_output_reorder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_POINTS   = 64,
    parameter int unsigned LOG2N      = 6
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [DATA_WIDTH-1:0] In_Real,
    input  logic [DATA_WIDTH-1:0] In_Imag,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [DATA_WIDTH-1:0] Out_Real,
    output logic [DATA_WIDTH-1:0] Out_Imag,
    output logic [LOG2N-1:0]      Out_Index,
    output logic                  Out_Last
);

    localparam int unsigned        WORD_W   = 2 * DATA_WIDTH;
    localparam logic [LOG2N-1:0]   LAST_CNT = LOG2N'(N_POINTS - 1);

    logic [WORD_W-1:0] mem [2][N_POINTS];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [LOG2N-1:0]  wr_cnt;
    logic [LOG2N-1:0]  rd_cnt;
    logic [LOG2N-1:0]  wr_addr;
    logic [WORD_W-1:0] rd_word;
    logic              wr_fire;
    logic              rd_fire;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Handshakes are combinational from registered bank state.
    assign In_Ready  = !full[wr_bank];
    assign Out_Valid = full[rd_bank];
    assign wr_fire   = In_Valid && In_Ready;
    assign rd_fire   = Out_Valid && Out_Ready;
    assign wr_addr   = bitrev(wr_cnt);

    // Bank/counter bookkeeping; write and read completions touch different Full bits.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + LOG2N'(1);
                if (wr_cnt == LAST_CNT) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + LOG2N'(1);
                if (rd_cnt == LAST_CNT) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    // Sample storage, deliberately without reset.
    always_ff @(posedge Clock) begin
        if (!Reset && wr_fire) begin
            mem[wr_bank][wr_addr] <= {In_Real, In_Imag};
        end
    end

    assign rd_word   = mem[rd_bank][rd_cnt];
    assign Out_Real  = rd_word[WORD_W-1:DATA_WIDTH];
    assign Out_Imag  = rd_word[DATA_WIDTH-1:0];
    assign Out_Index = rd_cnt;
    assign Out_Last  = Out_Valid && (rd_cnt == LAST_CNT);

endmodule

// File: tb/tb_fft64_output_reorder.sv
// Scoreboard bench for fft64_output_reorder: driver pushes expected natural-order frames,
// monitor pops and compares on every output handshake.
module tb_fft64_output_reorder;

    localparam int unsigned DW = 16;
    localparam int unsigned LN = 6;

    typedef struct {
        logic [LN-1:0] idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } exp_t;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          In_Valid;
    logic          In_Ready;
    logic [DW-1:0] In_Real;
    logic [DW-1:0] In_Imag;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [DW-1:0] Out_Real;
    logic [DW-1:0] Out_Imag;
    logic [LN-1:0] Out_Index;
    logic          Out_Last;

    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   mode      = 0;    // 0: Out_Ready=1, 1: Out_Ready=0, 2: random
    int   wr_k      = 0;
    int   frame_id  = 0;
    int   stalls    = 0;
    int   n_out     = 0;
    int   first_cyc = -1;
    int   last_cyc  = 0;
    exp_t q[$];

    logic        hold_v = 1'b0;
    logic [63:0] hold_snap;

    fft64_output_reorder #(.DATA_WIDTH(DW), .N_POINTS(64), .LOG2N(LN)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_Real  (In_Real),
        .In_Imag  (In_Imag),
        .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready),
        .Out_Real (Out_Real),
        .Out_Imag (Out_Imag),
        .Out_Index(Out_Index),
        .Out_Last (Out_Last)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LN-1:0] brev(input logic [LN-1:0] a);
        logic [LN-1:0] r;
        for (int i = 0; i < int'(LN); i++) r[i] = a[int'(LN)-1-i];
        return r;
    endfunction

    // Send one sample of the current frame; on frame completion queue its 64 natural-order bins.
    task automatic send_sample();
        logic [DW-1:0] re;
        logic          ok;
        exp_t          e;
        re       = DW'(frame_id * 256) + DW'(brev(LN'(wr_k)));
        In_Valid = 1'b1;
        In_Real  = re;
        In_Imag  = -re;
        ok       = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge Clock);
            if (In_Ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: In_Ready stuck at 0, required 1 within 3000 cycles");
        end
        @(posedge Clock);
        #1;
        In_Valid = 1'b0;
        wr_k++;
        if (wr_k == 64) begin
            for (int i = 0; i < 64; i++) begin
                e.idx  = LN'(i);
                e.re   = DW'(frame_id * 256 + i);
                e.im   = -e.re;
                e.last = (i == 63);
                q.push_back(e);
            end
            wr_k = 0;
            frame_id++;
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 6000; t++) begin
            if (q.size() == 0) break;
            @(negedge Clock);
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        @(negedge Clock);
        chk("idle_out_valid", 64'(Out_Valid), 64'd0);
    endtask

    // Out_Ready driver, updated just after each rising edge.
    initial begin
        Out_Ready = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            case (mode)
                0:       Out_Ready = 1'b1;
                1:       Out_Ready = 1'b0;
                default: Out_Ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: stability under backpressure, then scoreboard compare on handshake.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("hold_stable", {24'd0, Out_Valid, Out_Index, Out_Real, Out_Imag, Out_Last}, hold_snap);
            if (Out_Valid && Out_Ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got bin %0d, required no output", Out_Index);
                end else begin
                    e = q.pop_front();
                    chk("out_index", 64'(Out_Index), 64'(e.idx));
                    chk("out_real",  64'(Out_Real),  64'(e.re));
                    chk("out_imag",  64'(Out_Imag),  64'(e.im));
                    chk("out_last",  64'(Out_Last),  64'(e.last));
                end
                n_out++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            hold_v    = Out_Valid && !Out_Ready;
            hold_snap = {24'd0, Out_Valid, Out_Index, Out_Real, Out_Imag, Out_Last};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        Reset    = 1'b1;
        In_Valid = 1'b0;
        In_Real  = '0;
        In_Imag  = '0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;

        // 1: reset state
        @(negedge Clock);
        chk("rst_in_ready",  64'(In_Ready),  64'd1);
        chk("rst_out_valid", 64'(Out_Valid), 64'd0);
        chk("rst_out_index", 64'(Out_Index), 64'd0);
        chk("rst_out_last",  64'(Out_Last),  64'd0);
        @(posedge Clock);
        #1;

        // 2: single frame, first output one cycle after the 64th write
        for (int k = 0; k < 64; k++) send_sample();
        @(negedge Clock);
        chk("latency_out_valid", 64'(Out_Valid), 64'd1);
        chk("latency_out_index", 64'(Out_Index), 64'd0);
        wait_drain();

        // 3: three back-to-back frames, no input stall and no output gap
        @(posedge Clock);
        #1;
        stalls    = 0;
        first_cyc = -1;
        n0        = n_out;
        for (int k = 0; k < 192; k++) send_sample();
        wait_drain();
        chk("stream_stalls",    64'(stalls),              64'd0);
        chk("stream_out_count", 64'(n_out - n0),          64'd192);
        chk("stream_out_span",  64'(last_cyc - first_cyc), 64'd191);

        // 4: both banks full under backpressure
        mode = 1;
        @(posedge Clock);
        #1;
        for (int k = 0; k < 128; k++) send_sample();
        In_Valid = 1'b1;
        In_Real  = 16'hdead;
        In_Imag  = 16'hbeef;
        for (int t = 0; t < 4; t++) begin
            @(negedge Clock);
            chk("full_in_ready",  64'(In_Ready),  64'd0);
            chk("full_out_valid", 64'(Out_Valid), 64'd1);
            chk("full_out_index", 64'(Out_Index), 64'd0);
        end
        @(posedge Clock);
        #1;
        In_Valid = 1'b0;
        mode     = 0;
        wait_drain();

        // 5: random backpressure over 10 frames
        mode = 2;
        @(posedge Clock);
        #1;
        for (int k = 0; k < 640; k++) send_sample();
        wait_drain();
        mode = 0;

        // 6: reset at the 40th write of a frame while the previous frame is half drained
        @(posedge Clock);
        #1;
        for (int k = 0; k < 64 + 39; k++) send_sample();
        Reset    = 1'b1;
        In_Valid = 1'b1;
        In_Real  = 16'h1234;
        In_Imag  = 16'h5678;
        q.delete();
        wr_k = 0;
        frame_id++;
        @(posedge Clock);
        #1;
        Reset    = 1'b0;
        In_Valid = 1'b0;
        @(negedge Clock);
        chk("midrst_out_valid", 64'(Out_Valid), 64'd0);
        chk("midrst_in_ready",  64'(In_Ready),  64'd1);
        chk("midrst_out_index", 64'(Out_Index), 64'd0);
        chk("midrst_out_last",  64'(Out_Last),  64'd0);
        @(posedge Clock);
        #1;
        for (int k = 0; k < 64; k++) send_sample();
        @(negedge Clock);
        chk("post_rst_index", 64'(Out_Index), 64'd0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
